// File: rtl/tmds_channel_bank_encoder.sv
// tmds_channel_bank_encoder: N-lane TMDS character encoder with a 2-stage pipeline.
// Define TMDS_DATA_ISLAND_EN to build in TERC4 data-island and island-guard support.
module tmds_channel_bank_encoder #(
  parameter int NUM_CHANNELS = 3,
  parameter int DISP_WIDTH   = 5
) (
  input  logic                         pixelClock,
  input  logic                         resetN,
  input  logic                         symbolEnable,
  input  logic [2:0]                   periodMode,
  input  logic [NUM_CHANNELS*8-1:0]    pixelData,
  input  logic [NUM_CHANNELS*2-1:0]    controlBus,
  input  logic [NUM_CHANNELS*4-1:0]    auxData,
  output logic [NUM_CHANNELS*10-1:0]   tmdsCharacters,
  output logic                         characterValid
);

  localparam logic [2:0] MODE_VIDEO  = 3'b001;
  localparam logic [2:0] MODE_VGUARD = 3'b010;
  localparam logic [9:0] GUARD_A     = 10'b1011001100;
  localparam logic [9:0] GUARD_B     = 10'b0100110011;
  localparam logic [9:0] CTRL_00     = 10'b1101010100;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      2'b11: s = 10'b1010101011;
    endcase
    return s;
  endfunction

`ifdef TMDS_DATA_ISLAND_EN
  localparam logic [2:0] MODE_IGUARD = 3'b011;
  localparam logic [2:0] MODE_ISLAND = 3'b100;

  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] s;
    unique case (n)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      4'hF: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [NUM_CHANNELS*4-1:0] aux_d, aux_q;
`else
  logic unused_aux;
  assign unused_aux = ^auxData;
`endif

  logic [2:0]                mode_d, mode_q;
  logic [NUM_CHANNELS*2-1:0] ctrl_d, ctrl_q;
  logic                      valid1_d, valid1_q;
  logic                      cvalid_d, cvalid_q;

  always_comb begin
    mode_d   = mode_q;
    ctrl_d   = ctrl_q;
    valid1_d = valid1_q;
    cvalid_d = cvalid_q;
`ifdef TMDS_DATA_ISLAND_EN
    aux_d    = aux_q;
`endif
    if (symbolEnable) begin
      mode_d   = periodMode;
      ctrl_d   = controlBus;
      valid1_d = 1'b1;
      cvalid_d = cvalid_q | valid1_q;
`ifdef TMDS_DATA_ISLAND_EN
      aux_d    = auxData;
`endif
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      mode_q   <= '0;
      ctrl_q   <= '0;
      valid1_q <= 1'b0;
      cvalid_q <= 1'b0;
`ifdef TMDS_DATA_ISLAND_EN
      aux_q    <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      ctrl_q   <= ctrl_d;
      valid1_q <= valid1_d;
      cvalid_q <= cvalid_d;
`ifdef TMDS_DATA_ISLAND_EN
      aux_q    <= aux_d;
`endif
    end
  end

  assign characterValid = cvalid_q;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    localparam int GIDX = k % 3;

    logic [7:0]                   din;
    logic [1:0]                   c;
    logic [3:0]                   n1_in, n1_qm;
    logic                         use_xnor;
    logic [8:0]                   qm_d, qm_q;
    logic [9:0]                   nv_sym;
    logic [9:0]                   out_d, out_q;
    logic signed [5:0]            bal;
    logic signed [DISP_WIDTH-1:0] bal_w, two_q8, two_nq8;
    logic signed [DISP_WIDTH-1:0] cnt_d, cnt_q;
    logic                         cnt_pos, cnt_neg;

    assign din = pixelData[8*k +: 8];
    assign c   = ctrl_q[2*k +: 2];

    always_comb begin
      n1_in = '0;
      for (int i = 0; i < 8; i++) n1_in = n1_in + {3'b000, din[i]};
      use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !din[0]);
      qm_d = qm_q;
      if (symbolEnable) begin
        qm_d[0] = din[0];
        for (int i = 1; i < 8; i++)
          qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ din[i])
                             : (qm_d[i-1] ^ din[i]);
        qm_d[8] = ~use_xnor;
      end
    end

    always_comb begin
      nv_sym = ctrl_sym(c);
      unique case (1'b1)
        (mode_q == MODE_VGUARD):
          nv_sym = (GIDX == 1) ? GUARD_B : GUARD_A;
`ifdef TMDS_DATA_ISLAND_EN
        (mode_q == MODE_IGUARD):
          nv_sym = (GIDX == 0) ? terc4({2'b11, c}) : GUARD_B;
        (mode_q == MODE_ISLAND):
          nv_sym = terc4(aux_q[4*k +: 4]);
`endif
        default: ;
      endcase
    end

    // bal = N1 - N0 = 2*N1 - 8 over q_m[7:0]
    always_comb begin
      n1_qm = '0;
      for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, qm_q[i]};
      bal     = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;
      bal_w   = DISP_WIDTH'(bal);
      two_q8  = qm_q[8] ? DISP_WIDTH'(2) : '0;
      two_nq8 = qm_q[8] ? '0 : DISP_WIDTH'(2);
      cnt_neg = cnt_q[DISP_WIDTH-1];
      cnt_pos = !cnt_neg && (cnt_q != '0);
      out_d   = out_q;
      cnt_d   = cnt_q;
      if (symbolEnable) begin
        if (mode_q != MODE_VIDEO) begin
          out_d = nv_sym;
          cnt_d = '0;
        end else if ((cnt_q == '0) || (n1_qm == 4'd4)) begin
          out_d = {~qm_q[8], qm_q[8],
                   qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = qm_q[8] ? cnt_q + bal_w : cnt_q - bal_w;
        end else if ((cnt_pos && (n1_qm > 4'd4)) ||
                     (cnt_neg && (n1_qm < 4'd4))) begin
          out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d = cnt_q + two_q8 - bal_w;
        end else begin
          out_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d = cnt_q + bal_w - two_nq8;
        end
      end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
      if (!resetN) begin
        qm_q  <= '0;
        out_q <= CTRL_00;
        cnt_q <= '0;
      end else begin
        qm_q  <= qm_d;
        out_q <= out_d;
        cnt_q <= cnt_d;
      end
    end

    assign tmdsCharacters[10*k +: 10] = out_q;
  end

endmodule

// File: tb/tb_tmds_channel_bank_encoder.sv
// Bench for tmds_channel_bank_encoder: directed scenarios plus randomized
// traffic against a symbol-level reference model.
module tb_tmds_channel_bank_encoder;

  localparam int NCH = 3;
  localparam int DW  = 5;

  logic              pixelClock = 1'b0;
  logic              resetN = 1'b0;
  logic              symbolEnable = 1'b0;
  logic [2:0]        periodMode = '0;
  logic [NCH*8-1:0]  pixelData = '0;
  logic [NCH*2-1:0]  controlBus = '0;
  logic [NCH*4-1:0]  auxData = '0;
  logic [NCH*10-1:0] tmdsCharacters;
  logic              characterValid;

  tmds_channel_bank_encoder #(.NUM_CHANNELS(NCH), .DISP_WIDTH(DW)) dut (
    .pixelClock(pixelClock),
    .resetN(resetN),
    .symbolEnable(symbolEnable),
    .periodMode(periodMode),
    .pixelData(pixelData),
    .controlBus(controlBus),
    .auxData(auxData),
    .tmdsCharacters(tmdsCharacters),
    .characterValid(characterValid)
  );

  always #5 pixelClock = ~pixelClock;

  typedef struct packed {
    logic [2:0]       mode;
    logic [NCH*8-1:0] d;
    logic [NCH*2-1:0] c;
    logic [NCH*4-1:0] a;
  } samp_t;

  samp_t             pend[$];
  int                cnt_m [NCH];
  logic [NCH*10-1:0] exp_chars;
  logic              exp_valid;
  int                checks = 0;
  int                errors = 0;

  logic [9:0] ctrl_tbl [4] = '{10'b1101010100, 10'b0010101011,
                               10'b0101010100, 10'b1010101011};
  logic [9:0] terc_tbl [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < NCH; k++) cnt_m[k] = 0;
    exp_chars = {NCH{ctrl_tbl[0]}};
    exp_valid = 1'b0;
  endtask

  // Symbol rules written directly from the character tables and DVI balance rule.
  task automatic encode_lane(input int k, input samp_t s, output logic [9:0] sym);
    logic [7:0] d;
    logic [1:0] c;
    logic [3:0] a;
    logic [7:0] mask;
    logic [8:0] q;
    int ones, n1, n0;
    bit inv;
    d = s.d[8*k +: 8];
    c = s.c[2*k +: 2];
    a = s.a[4*k +: 4];
    sym = ctrl_tbl[c];
    if (s.mode == 3'd1) begin
      ones = $countones(d);
      inv = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      for (int i = 0; i < 8; i++) begin
        mask = 8'((1 << (i + 1)) - 1);
        q[i] = (^(d & mask)) ^ (inv & i[0]);
      end
      q[8] = !inv;
      n1 = $countones(q[7:0]);
      n0 = 8 - n1;
      if (cnt_m[k] == 0 || n1 == n0) begin
        sym = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        cnt_m[k] += q[8] ? (n1 - n0) : (n0 - n1);
      end else if ((cnt_m[k] > 0 && n1 > n0) || (cnt_m[k] < 0 && n0 > n1)) begin
        sym = {1'b1, q[8], ~q[7:0]};
        cnt_m[k] += 2 * int'(q[8]) + (n0 - n1);
      end else begin
        sym = {1'b0, q[8], q[7:0]};
        cnt_m[k] += (n1 - n0) - 2 * int'(!q[8]);
      end
    end else begin
      cnt_m[k] = 0;
      if (s.mode == 3'd2)
        sym = (k % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
`ifdef TMDS_DATA_ISLAND_EN
      if (s.mode == 3'd3)
        sym = (k % 3 == 0) ? terc_tbl[{2'b11, c}] : 10'b0100110011;
      if (s.mode == 3'd4)
        sym = terc_tbl[a];
`endif
    end
  endtask

  // Each enabled edge emits the symbol sampled on the previous enabled edge.
  task automatic model_edge();
    samp_t s;
    logic [9:0] sym;
    s.mode = periodMode;
    s.d = pixelData;
    s.c = controlBus;
    s.a = auxData;
    pend.push_back(s);
    if (pend.size() > 1) begin
      s = pend.pop_front();
      for (int k = 0; k < NCH; k++) begin
        encode_lane(k, s, sym);
        exp_chars[10*k +: 10] = sym;
      end
      exp_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge pixelClock);
    if (symbolEnable && resetN) model_edge();
    @(negedge pixelClock);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    symbolEnable = 1'b0;
    repeat (3) @(negedge pixelClock);
    model_reset();
    checks++;
    if (tmdsCharacters !== exp_chars || characterValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b want %h/0", tmdsCharacters, characterValid, exp_chars);
    end
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tmdsCharacters !== {NCH{10'b1101010100}} || characterValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle %0d: got %h/%b want %h/0", i, tmdsCharacters,
                 characterValid, {NCH{10'b1101010100}});
      end
    end
  endtask

  task automatic test_control();
    periodMode = 3'd0;
    controlBus = {NCH{2'b01}};
    symbolEnable = 1'b1;
    tick();
    checks++;
    if (tmdsCharacters !== exp_chars || characterValid !== exp_valid) begin
      errors++;
      $display("FAIL ctrl_first: got %h/%b want %h/%b", tmdsCharacters, characterValid, exp_chars, exp_valid);
    end
    tick();
    checks++;
    if (tmdsCharacters !== {NCH{10'b0010101011}} || characterValid !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_01: got %h/%b want %h/1", tmdsCharacters, characterValid, {NCH{10'b0010101011}});
    end
  endtask

  task automatic test_video_dc();
    periodMode = 3'd1;
    pixelData = '0;
    tick();
    checks++;
    if (tmdsCharacters !== exp_chars) begin
      errors++;
      $display("FAIL video_lead: got %h want %h", tmdsCharacters, exp_chars);
    end
    tick();
    checks++;
    if (tmdsCharacters !== {NCH{10'b0100000000}}) begin
      errors++;
      $display("FAIL video_00_a: got %h want %h", tmdsCharacters, {NCH{10'b0100000000}});
    end
    tick();
    checks++;
    if (tmdsCharacters !== {NCH{10'b1111111111}}) begin
      errors++;
      $display("FAIL video_00_b: got %h want %h", tmdsCharacters, {NCH{10'b1111111111}});
    end
  endtask

  task automatic test_guard();
    logic [NCH*10-1:0] g;
    g = {10'b1011001100, 10'b0100110011, 10'b1011001100};
    periodMode = 3'd2;
    tick();
    checks++;
    if (tmdsCharacters !== exp_chars) begin
      errors++;
      $display("FAIL guard_lead: got %h want %h", tmdsCharacters, exp_chars);
    end
    tick();
    checks++;
    if (tmdsCharacters !== g) begin
      errors++;
      $display("FAIL guard_vid: got %h want %h", tmdsCharacters, g);
    end
    periodMode = 3'd1;
    pixelData = '0;
    tick();
    tick();
    checks++;
    if (tmdsCharacters !== {NCH{10'b0100000000}}) begin
      errors++;
      $display("FAIL guard_clear: got %h want %h", tmdsCharacters, {NCH{10'b0100000000}});
    end
  endtask

  task automatic test_stall();
    periodMode = 3'd1;
    for (int i = 0; i < 16; i++) begin
      symbolEnable = !(i >= 6 && i < 11);
      pixelData = NCH*8'($urandom);
      if (!symbolEnable) periodMode = 3'($urandom_range(0, 7));
      else periodMode = 3'd1;
      tick();
      checks++;
      if (tmdsCharacters !== exp_chars || characterValid !== exp_valid) begin
        errors++;
        $display("FAIL stall %0d: got %h/%b want %h/%b", i, tmdsCharacters, characterValid, exp_chars, exp_valid);
      end
    end
    symbolEnable = 1'b1;
  endtask

  task automatic test_island();
    logic [NCH*10-1:0] w0, w1;
`ifdef TMDS_DATA_ISLAND_EN
    w0 = {NCH{10'b1010011100}};
    w1 = {NCH{10'b1011000011}};
`else
    w0 = {NCH{10'b1101010100}};
    w1 = {NCH{10'b1101010100}};
`endif
    periodMode = 3'd4;
    controlBus = '0;
    auxData = '0;
    tick();
    tick();
    checks++;
    if (tmdsCharacters !== w0) begin
      errors++;
      $display("FAIL island_0: got %h want %h", tmdsCharacters, w0);
    end
    auxData = '1;
    tick();
    tick();
    checks++;
    if (tmdsCharacters !== w1) begin
      errors++;
      $display("FAIL island_f: got %h want %h", tmdsCharacters, w1);
    end
    periodMode = 3'd3;
    for (int i = 0; i < 8; i++) begin
      controlBus = NCH*2'($urandom);
      tick();
      checks++;
      if (tmdsCharacters !== exp_chars) begin
        errors++;
        $display("FAIL island_guard %0d: got %h want %h", i, tmdsCharacters, exp_chars);
      end
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      symbolEnable = ($urandom_range(0, 9) != 0);
      periodMode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      pixelData = NCH*8'($urandom);
      controlBus = NCH*2'($urandom);
      auxData = NCH*4'($urandom);
      tick();
      checks++;
      if (tmdsCharacters !== exp_chars || characterValid !== exp_valid) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random %0d: got %h/%b want %h/%b", i, tmdsCharacters, characterValid, exp_chars, exp_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    symbolEnable = 1'b1;
    periodMode = 3'd1;
    pixelData = NCH*8'($urandom);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    checks++;
    if (tmdsCharacters !== exp_chars || characterValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b want %h/0", tmdsCharacters, characterValid, exp_chars);
    end
    @(negedge pixelClock);
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pixelData = NCH*8'($urandom);
      tick();
      checks++;
      if (tmdsCharacters !== exp_chars || characterValid !== exp_valid) begin
        errors++;
        $display("FAIL reset_resume %0d: got %h/%b want %h/%b", i, tmdsCharacters, characterValid, exp_chars, exp_valid);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_control();
    test_video_dc();
    test_guard();
    test_stall();
    test_island();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
